// File: rtl/FLP_pkg.sv
// Floating-point format constants plus the divider quotient width and FSM state type.
// The format is sign | biased exponent | fraction, with an implicit leading one.
package FLP_pkg;

    localparam int OVERALL_BITS      = 32;
    localparam int EXPONENT_BITS     = 8;
    localparam int SIGNIFICANT_BITS  = 23;
    localparam int EXPONENT_BIAS     = 127;

    localparam int DIV_QUOTIENT_BITS = SIGNIFICANT_BITS + 2;
    localparam int DIV_COUNT_BITS    = $clog2(DIV_QUOTIENT_BITS);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM
    } flp_div_state_t;

endpackage

// File: rtl/intdiv_seq.sv
// Unsigned restoring divider: one quotient bit per step, DIV_QUOTIENT_BITS steps after load.
// No handshake of its own; the caller sequences load/step and watches last.
module intdiv_seq
    import FLP_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         step,
    input  logic [SIGNIFICANT_BITS:0]    dividend,
    input  logic [SIGNIFICANT_BITS:0]    divisor,
    output logic [DIV_QUOTIENT_BITS-1:0] quotient,
    output logic                         last
);

    localparam int S  = SIGNIFICANT_BITS;
    // Remainder stays below 2*divisor, so S+2 magnitude bits plus one sign bit for the trial.
    localparam int RW = S + 3;

    logic [RW-1:0]             rem_q;
    logic [S:0]                dvs_q;
    logic [DIV_COUNT_BITS-1:0] cnt_q;
    logic [RW-1:0]             trial;
    logic                      qbit;

    assign trial = rem_q - {2'b00, dvs_q};
    assign qbit  = ~trial[RW-1];
    assign last  = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            quotient <= '0;
        end else if (load) begin
            rem_q    <= {2'b00, dividend};
            dvs_q    <= divisor;
            cnt_q    <= DIV_COUNT_BITS'(S + 1);
            quotient <= '0;
        end else if (step) begin
            rem_q    <= (qbit ? trial : rem_q) << 1;
            quotient <= {quotient[DIV_QUOTIENT_BITS-2:0], qbit};
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/flp_divider.sv
// Iterative FLP divider a/b: S+3 edges accept-to-done, one op in flight, start ignored while busy.
// FLP_DIV_EARLY_OUT_EN: zero-exponent operands skip the divide loop and finish at edge 1.
module flp_divider
    import FLP_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [OVERALL_BITS-1:0] a,
    input  logic [OVERALL_BITS-1:0] b,
    output logic [OVERALL_BITS-1:0] result,
    output logic                    done,
    output logic                    busy
);

    localparam int S = SIGNIFICANT_BITS;
    localparam int E = EXPONENT_BITS;
    localparam logic signed [E+1:0] BIAS_W = (E + 2)'(EXPONENT_BIAS);
    localparam logic signed [E+1:0] SAT_W  = (E + 2)'((1 << E) - 1);
    localparam logic signed [E+1:0] ZERO_W = '0;
    localparam logic signed [E+1:0] ONE_W  = (E + 2)'(1);

    flp_div_state_t state_q, state_d;

    logic                         load, step, finish, last;
    logic                         sign_q;
    logic [E-1:0]                 ea_q, eb_q;
    logic [E-1:0]                 ea_in, eb_in;
    logic [S:0]                   ma_in, mb_in;
    logic [DIV_QUOTIENT_BITS-1:0] quotient;
    logic signed [E+1:0]          e_full, adj;
    logic [S-1:0]                 frac;
    logic [OVERALL_BITS-2:0]      mag;

    assign ea_in = a[OVERALL_BITS-2 -: E];
    assign eb_in = b[OVERALL_BITS-2 -: E];
    assign ma_in = {|ea_in, a[S-1:0]};
    assign mb_in = {|eb_in, b[S-1:0]};

    intdiv_seq u_intdiv_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .dividend (ma_in),
        .divisor  (mb_in),
        .quotient (quotient),
        .last     (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
`ifdef FLP_DIV_EARLY_OUT_EN
                    state_d = (ea_in == '0 || eb_in == '0) ? NORM : DIVIDE;
`else
                    state_d = DIVIDE;
`endif
                end
            end
            DIVIDE: begin
                step = 1'b1;
                if (last) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Quotient lies in [2^S, 2^(S+2)); its top bit picks the normalisation shift.
    always_comb begin
        adj    = quotient[S+1] ? ZERO_W : ONE_W;
        e_full = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS_W - adj;
        frac   = quotient[S+1] ? quotient[S:1] : quotient[S-1:0];
        mag    = '0;
        if (ea_q == '0) begin
            mag = '0;
        end else if (eb_q == '0) begin
            mag = '1;
        end else if (e_full <= ZERO_W) begin
            mag = '0;
        end else if (e_full >= SAT_W) begin
            mag = '1;
        end else begin
            mag = {e_full[E-1:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= finish;
            if (finish) begin
                result <= {sign_q, mag};
            end
            if (load) begin
                sign_q <= a[OVERALL_BITS-1] ^ b[OVERALL_BITS-1];
                ea_q   <= ea_in;
                eb_q   <= eb_in;
            end
        end
    end

endmodule
